// File: rtl/switch_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : switch_display_pkg
//  Brief   : Shared constants for the switch counter display: 7-segment
//            table, digit constants, display mode encodings, channel bound.
//  Revision: 1.0  initial release
// ============================================================================
package switch_display_pkg;

    // Upper bound on the number of switch/LED/digit channels
    localparam int CHANNELS_MAX = 6;

    // Display mode encodings
    localparam int MODE_LEVEL = 0;
    localparam int MODE_COUNT = 1;

    // Active-low {dp,g,f,e,d,c,b,a} codes for the level digits, dp off
    localparam logic [7:0] SEG_ZERO = 8'hC0;
    localparam logic [7:0] SEG_ONE  = 8'hF9;

    // Decimal digit table, index 0 in the least significant byte, dp off
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // BCD digit to segment code; non-decimal values blank the digit
    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] seg;
        seg = 8'hFF;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_counter_display_if.sv
`default_nettype none
// ============================================================================
//  Module  : switch_counter_display_if
//  Brief   : Board-facing signal bundle: raw switches and clear in, LEDs
//            and 7-segment digits out.
//  Revision: 1.0  initial release
// ============================================================================
interface switch_counter_display_if #(
    parameter int CHANNELS = 6
);
    logic [CHANNELS-1:0]   SW;
    logic                  CLR;
    logic [CHANNELS-1:0]   LEDR;
    logic [8*CHANNELS-1:0] HEX;

    // Board / testbench side
    modport master (
        output SW,
        output CLR,
        input  LEDR,
        input  HEX
    );

    // Display core side
    modport slave (
        input  SW,
        input  CLR,
        output LEDR,
        output HEX
    );
endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module  : switch_debouncer
//  Brief   : Two-flop synchroniser followed by a hold-time debouncer for one
//            switch. Emits the accepted level and a same-cycle rise pulse.
//  Revision: 1.0  initial release
// ============================================================================
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic raw_i,
    output logic      stable_o,
    output logic      rise_o
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles of disagreement; accept on the last one,
    // and any agreement (including a reversal) restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, accepted level and hold counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    // High on the cycle whose edge will move the accepted level 0->1
    assign rise_o   = ~stable_q & stable_d;

endmodule
`default_nettype wire

// File: rtl/switch_counter_display.sv
`default_nettype none
// ============================================================================
//  Module  : switch_counter_display
//  Brief   : Per-channel debounced switches driving LEDs and 7-segment
//            digits that show either the level or a mod-10 press count.
//  Revision: 1.0  initial release
// ============================================================================
module switch_counter_display
    import switch_display_pkg::*;
#(
    parameter int CHANNELS        = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MODE            = 1
) (
    input  wire logic                 CLOCK_50,
    input  wire logic                 RESET_N,
    switch_counter_display_if.slave   bus
);
    logic [CHANNELS-1:0] stable_w;
    logic [CHANNELS-1:0] rise_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [3:0] count_q;
        logic [3:0] count_d;
        logic [7:0] seg_w;
        logic [7:0] digit_w;

        switch_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk_i    (CLOCK_50),
            .rst_ni   (RESET_N),
            .raw_i    (bus.SW[i]),
            .stable_o (stable_w[i]),
            .rise_o   (rise_w[i])
        );

        // BCD press count; clear wins over a coincident increment
        always_comb begin
            count_d = count_q;
            if (bus.CLR) begin
                count_d = 4'd0;
            end else if (rise_w[i]) begin
                count_d = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
            end
        end

        // Press count register
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                count_q <= 4'd0;
            end else begin
                count_q <= count_d;
            end
        end

        // Digit decode from registered state only, so it moves with LEDR
        always_comb begin
            seg_w = seg_decode(count_q);
            if (MODE == MODE_LEVEL) begin
                digit_w = stable_w[i] ? SEG_ONE : SEG_ZERO;
            end else begin
                digit_w = {~stable_w[i], seg_w[6:0]};
            end
        end

        assign bus.HEX[8*i +: 8] = digit_w;
    end

    assign bus.LEDR = stable_w;

endmodule
`default_nettype wire

// File: tb/tb_switch_counter_display.sv
`default_nettype none
// ============================================================================
//  Module  : tb_switch_counter_display
//  Brief   : Self-checking bench for switch_counter_display, running a
//            count-mode and a level-mode instance side by side.
//  Revision: 1.0  initial release
// ============================================================================
module tb_switch_counter_display;
    localparam int CH = 6;
    localparam int DB = 4;

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N  = 1'b0;
    logic [CH-1:0] sw      = '0;
    logic         clr      = 1'b0;

    int checks = 0;
    int errors = 0;

    switch_counter_display_if #(.CHANNELS(CH)) bus1 ();
    switch_counter_display_if #(.CHANNELS(CH)) bus0 ();

    assign bus1.SW  = sw;
    assign bus1.CLR = clr;
    assign bus0.SW  = sw;
    assign bus0.CLR = clr;

    switch_counter_display #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .MODE(1)
    ) dut_count (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus1)
    );

    switch_counter_display #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .MODE(0)
    ) dut_level (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- reference model ----------------
    logic [7:0]    seg_ref [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [CH-1:0] hist [DB+1];   // hist[j]: switches sampled j+1 edges ago
    logic [CH-1:0] m_stable;
    int            m_count [CH];

    function automatic void model_reset();
        for (int j = 0; j <= DB; j++) hist[j] = '0;
        m_stable = '0;
        for (int c = 0; c < CH; c++) m_count[c] = 0;
    endfunction

    // A level is accepted once the synchronised level (switch value two
    // edges back) has disagreed with the accepted level for DB edges.
    function automatic void model_step(input logic [CH-1:0] s, input logic c_in);
        logic acc;
        for (int c = 0; c < CH; c++) begin
            acc = 1'b1;
            for (int k = 1; k <= DB; k++) begin
                if (hist[k][c] == m_stable[c]) acc = 1'b0;
            end
            if (acc) begin
                m_stable[c] = ~m_stable[c];
                if (m_stable[c]) m_count[c] = (m_count[c] + 1) % 10;
            end
            if (c_in) m_count[c] = 0;
        end
        for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
        hist[0] = s;
    endfunction

    function automatic logic [8*CH-1:0] exp_hex(input int mode);
        logic [8*CH-1:0] r;
        logic [7:0]      d;
        for (int c = 0; c < CH; c++) begin
            if (mode == 0) begin
                d = m_stable[c] ? 8'hF9 : 8'hC0;
            end else begin
                d    = seg_ref[m_count[c]];
                d[7] = ~m_stable[c];
            end
            r[8*c +: 8] = d;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        if (RESET_N) model_step(sw, clr);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        sw      = '0;
        clr     = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus1.LEDR !== 6'b0) begin
            errors++; $display("FAIL reset_ledr: got %b expected %b", bus1.LEDR, 6'b0);
        end
        checks++;
        if (bus1.HEX !== {CH{8'hC0}}) begin
            errors++; $display("FAIL reset_hex_count: got %h expected %h", bus1.HEX, {CH{8'hC0}});
        end
        checks++;
        if (bus0.HEX !== {CH{8'hC0}}) begin
            errors++; $display("FAIL reset_hex_level: got %h expected %h", bus0.HEX, {CH{8'hC0}});
        end
        #1 RESET_N = 1'b1;
    endtask

    task automatic test_single_press();
        sw[0] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus1.LEDR[0] !== 1'b0) begin
            errors++; $display("FAIL press_early: got %b expected 0", bus1.LEDR[0]);
        end
        tick();
        checks++;
        if (bus1.LEDR[0] !== 1'b1) begin
            errors++; $display("FAIL press_latency: got %b expected 1", bus1.LEDR[0]);
        end
        checks++;
        if (bus1.HEX[7:0] !== 8'h79) begin
            errors++; $display("FAIL press_digit0: got %h expected %h", bus1.HEX[7:0], 8'h79);
        end
        checks++;
        if (bus0.HEX[7:0] !== 8'hF9) begin
            errors++; $display("FAIL press_level_digit0: got %h expected %h", bus0.HEX[7:0], 8'hF9);
        end
    endtask

    task automatic test_glitch();
        sw[2] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sw[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus1.LEDR[2] !== 1'b0 || bus1.HEX[23:16] !== 8'hC0) begin
                errors++;
                $display("FAIL glitch_ch2: got led %b digit %h expected led 0 digit c0",
                         bus1.LEDR[2], bus1.HEX[23:16]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        for (int k = 1; k <= 10; k++) begin
            sw[5] = 1'b1;
            for (int i = 0; i < 8; i++) tick();
            e = seg_ref[k % 10];
            e[7] = 1'b0;
            checks++;
            if (bus1.HEX[47:40] !== e) begin
                errors++; $display("FAIL wrap_press_%0d: got %h expected %h", k, bus1.HEX[47:40], e);
            end
            sw[5] = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            e = seg_ref[k % 10];
            checks++;
            if (bus1.HEX[47:40] !== e) begin
                errors++; $display("FAIL wrap_release_%0d: got %h expected %h", k, bus1.HEX[47:40], e);
            end
        end
    endtask

    task automatic test_clr_coincide();
        sw[1] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (bus1.LEDR[1] !== 1'b1) begin
            errors++; $display("FAIL clr_ledr1: got %b expected 1", bus1.LEDR[1]);
        end
        checks++;
        if (bus1.HEX[15:8] !== 8'h40) begin
            errors++; $display("FAIL clr_digit1: got %h expected %h", bus1.HEX[15:8], 8'h40);
        end
        checks++;
        if (bus1.HEX !== exp_hex(1)) begin
            errors++; $display("FAIL clr_all_digits: got %h expected %h", bus1.HEX, exp_hex(1));
        end
    endtask

    task automatic test_reset_mid();
        sw = 6'b111111;
        for (int i = 0; i < 8; i++) tick();
        sw[3] = 1'b0;
        tick();
        tick();
        RESET_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus0.LEDR !== 6'b0 || bus0.HEX !== {CH{8'hC0}} || bus1.HEX !== {CH{8'hC0}}) begin
            errors++;
            $display("FAIL reset_mid_clear: got led %b hex0 %h hex1 %h expected 0 and all c0",
                     bus0.LEDR, bus0.HEX, bus1.HEX);
        end
        #1 RESET_N = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus0.LEDR !== 6'b0) begin
            errors++; $display("FAIL reset_mid_early: got %b expected 000000", bus0.LEDR);
        end
        tick();
        checks++;
        if (bus0.LEDR !== 6'b110111) begin
            errors++; $display("FAIL reset_mid_ledr: got %b expected 110111", bus0.LEDR);
        end
        checks++;
        if (bus0.HEX !== 48'hF9F9C0F9F9F9) begin
            errors++; $display("FAIL reset_mid_level_hex: got %h expected %h", bus0.HEX, 48'hF9F9C0F9F9F9);
        end
        checks++;
        if (bus1.HEX !== 48'h7979C0797979) begin
            errors++; $display("FAIL reset_mid_count_hex: got %h expected %h", bus1.HEX, 48'h7979C0797979);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (hold == 0) begin
                sw   = sw ^ CH'($urandom_range(0, 63));
                hold = $urandom_range(1, 7);
            end
            hold--;
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                RESET_N = 1'b0;
                model_reset();
                #1 RESET_N = 1'b1;
            end
            tick();
            checks++;
            if (bus1.LEDR !== m_stable || bus0.LEDR !== m_stable) begin
                errors++;
                $display("FAIL rand_ledr cycle %0d: got %b/%b expected %b",
                         n, bus1.LEDR, bus0.LEDR, m_stable);
            end
            checks++;
            if (bus1.HEX !== exp_hex(1)) begin
                errors++; $display("FAIL rand_hex_count cycle %0d: got %h expected %h", n, bus1.HEX, exp_hex(1));
            end
            checks++;
            if (bus0.HEX !== exp_hex(0)) begin
                errors++; $display("FAIL rand_hex_level cycle %0d: got %h expected %h", n, bus0.HEX, exp_hex(0));
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap();
        test_clr_coincide();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_counter_display.md
SWITCH_COUNTER_DISPLAY -- requirements
Module: switch_counter_display

Interface
REQ-001 Parameter CHANNELS, default 6, number of switch/LED/digit channels; legal range 1..6.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, clocks a synchronised switch level must hold before acceptance; legal range 2..2^20.
REQ-003 Parameter MODE, default 1, selects the digit source: 0 = level (digit shows 0/1), 1 = count (digit shows rising-edge count mod 10).
REQ-004 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-005 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-006 SW  input  CHANNELS  raw asynchronous switch levels; SW[i] belongs to channel i.
REQ-007 CLR  input  1  synchronous, active-high clear of all channel counts.
REQ-008 LEDR  output  CHANNELS  debounced switch level per channel, registered.
REQ-009 HEX  output  8*CHANNELS  per-channel 7-segment code; channel i occupies bits 8i+7..8i, ordered {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-010 Each SW[i] SHALL pass through a two-flop synchroniser before any other use.
REQ-011 Each channel SHALL hold a stable level plus a debounce counter; while the synchronised level equals stable, the counter is held at 0.
REQ-012 While the synchronised level differs from stable, the counter SHALL increment each cycle; on the cycle it reaches DEBOUNCE_CYCLES-1, stable takes the synchronised level and the counter returns to 0.
REQ-013 A reversal before acceptance SHALL return the counter to 0 with stable unchanged; glitches shorter than DEBOUNCE_CYCLES never reach LEDR.
REQ-014 Latency from a clean SW edge to the LEDR change SHALL be exactly 2+DEBOUNCE_CYCLES clocks.
REQ-015 LEDR[i] SHALL equal stable[i].
REQ-016 Each channel SHALL hold a 4-bit BCD count, incremented on the same edge on which stable goes 0->1; 9 wraps to 0; 1->0 transitions do not count.
REQ-017 CLR SHALL zero every count on the next edge; when CLR and an increment coincide, the count becomes 0.
REQ-018 CLR SHALL NOT affect stable, LEDR, or the debounce counters.
REQ-019 HEX SHALL be a combinational decode of registered state only, so it changes in the same cycle as LEDR.
REQ-020 In MODE 0, digit i SHALL show stable[i]: 1 -> 8'hF9, 0 -> 8'hC0, dp off.
REQ-021 In MODE 1, digit i SHALL show count[i] using the standard active-low table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
REQ-022 In MODE 1, dp (bit 8i+7) SHALL be 0 (lit) while stable[i]=1 and 1 otherwise.
REQ-023 Channels SHALL be fully independent; simultaneous edges on all channels are each processed without interaction.

Reset
REQ-024 RESET_N low SHALL immediately clear the synchronisers, stable, debounce counters and counts to 0, so LEDR=0 and every digit shows 8'hC0.
REQ-025 Reset asserted mid-debounce SHALL discard the pending change; after release, a still-high switch is re-accepted 2+DEBOUNCE_CYCLES clocks later and counts once.
REQ-026 Reset de-assertion SHALL be accepted on any edge; the first state update occurs on the first CLOCK_50 rising edge with RESET_N high.

Structure
REQ-027 Package switch_display_pkg SHALL hold the 10-entry segment table, the SEG_ONE/SEG_ZERO constants, the MODE encodings, and the CHANNELS upper bound.
REQ-028 Per-channel synchroniser plus debouncer SHALL be a sub-module switch_debouncer (ports: clock, reset, raw in, stable out, rise pulse), instantiated CHANNELS times in a generate loop.
REQ-029 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); no other width depends on DEBOUNCE_CYCLES.

Verification (bench: CHANNELS=6, DEBOUNCE_CYCLES=4)
REQ-030 Reset with SW=6'b000000 -> LEDR=0 and all six digits 8'hC0, before any clock edge.
REQ-031 SW[0] 0->1 held (MODE 1) -> LEDR[0]=1 exactly 6 clocks later; digit0 = 8'h79 (count 1, dp lit).
REQ-032 SW[2] high for 3 clocks then low -> LEDR[2] stays 0 and digit2 stays 8'hC0.
REQ-033 Ten clean press/release cycles on SW[5] -> digit5 goes through F9..90 and returns to C0 (wrap), dp tracking the switch.
REQ-034 CLR pulsed on the same edge as an SW[1] acceptance -> count1=0, LEDR[1]=1, digit1 = 8'h40.
REQ-035 MODE 0 build, all switches high, then RESET_N pulsed low mid-debounce of a falling SW[3] -> outputs zero immediately; after release, LEDR=6'b110111 after 6 clocks, digits F9 except digit3 at C0.
